// File: rtl/tx_frame_pkg.sv
// Shared types and constants for the 64b/66b TX frame scheduler.
package tx_frame_pkg;

   localparam logic [1:0] SYNC_DATA = 2'b01;
   localparam logic [1:0] SYNC_CTRL = 2'b10;
   localparam logic [5:0] SEQ_MAX   = 6'd32;

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_RUN  = 2'd1,
      ST_CC   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SRC_IDLE = 2'd0,
      SRC_DATA = 2'd1,
      SRC_SVC  = 2'd2,
      SRC_CC   = 2'd3
   } src_t;

   // Only user data blocks carry the data sync header; everything else is control.
   function automatic logic [1:0] sync_of(input src_t src);
      return (src == SRC_DATA) ? SYNC_DATA : SYNC_CTRL;
   endfunction

endpackage

// File: rtl/tx_frame_scheduler_seq.sv
// GT gearbox sequence counter: free-running 0..SEQ_MAX, flags the pause cycle.
module tx_seq_counter
   import tx_frame_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   output logic [5:0] seq,
   output logic       pause
);

   logic [5:0] seq_r;

   // Sequence register, wraps from SEQ_MAX back to zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seq_r <= 6'd0;
      end else if (seq_r == SEQ_MAX) begin
         seq_r <= 6'd0;
      end else begin
         seq_r <= seq_r + 6'd1;
      end
   end

   assign seq   = seq_r;
   assign pause = (seq_r == SEQ_MAX);

endmodule

// File: rtl/tx_frame_scheduler.sv
// Per-slot scheduler feeding the TX scrambler: INIT idles, service/data
// arbitration with alternation, periodic atomic CC bursts, gearbox pause stalls.
module tx_frame_scheduler
   import tx_frame_pkg::*;
#(
   parameter int unsigned INIT_IDLES = 64,
   parameter int unsigned CC_PERIOD  = 5000,
   parameter int unsigned CC_COUNT   = 3,
   parameter logic [63:0] IDLE_WORD  = 64'h7800_0000_0000_0000,
   parameter logic [63:0] CC_WORD    = 64'h7880_0000_0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] data_i,
   input  logic        data_valid_i,
   output logic        data_ready_o,
   input  logic [63:0] svc_i,
   input  logic        svc_valid_i,
   output logic        svc_ready_o,
   output logic [63:0] scr_data_o,
   output logic [1:0]  scr_sync_o,
   output logic        scr_enable_o,
   output logic [5:0]  tx_sequence_o,
   output logic        link_up_o
);

   localparam int unsigned INIT_W  = $clog2(INIT_IDLES + 1);
   localparam int unsigned CC_W    = $clog2(CC_PERIOD);
   localparam int unsigned BURST_W = $clog2(CC_COUNT + 1);
   localparam logic [INIT_W-1:0]  INIT_LAST  = INIT_W'(INIT_IDLES - 1);
   localparam logic [CC_W-1:0]    CC_LAST    = CC_W'(CC_PERIOD - 1);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(CC_COUNT - 1);

   state_t              state_r, state_s;
   logic [INIT_W-1:0]   init_cnt_r, init_cnt_s;
   logic [CC_W-1:0]     cc_cnt_r, cc_cnt_s;
   logic [BURST_W-1:0]  burst_cnt_r, burst_cnt_s;
   logic                last_svc_r, last_svc_s;
   logic                link_up_r, link_up_s;
   logic [63:0]         scr_data_r;
   logic [1:0]          scr_sync_r;
   logic                scr_enable_r;
   src_t                src_s;
   logic                data_ready_s, svc_ready_s;
   logic                cc_due_s;
   logic                pause_s;
   logic [5:0]          seq_s;
   logic [63:0]         frame_data_s;

   tx_seq_counter u_seq (
      .clk   (clk),
      .rst_n (rst_n),
      .seq   (seq_s),
      .pause (pause_s)
   );

   assign cc_due_s = (cc_cnt_r == CC_LAST);

   // Next-state, slot arbitration and ready generation; nothing moves on a pause cycle
   always_comb begin
      state_s      = state_r;
      init_cnt_s   = init_cnt_r;
      cc_cnt_s     = cc_cnt_r;
      burst_cnt_s  = burst_cnt_r;
      last_svc_s   = last_svc_r;
      link_up_s    = link_up_r;
      src_s        = SRC_IDLE;
      data_ready_s = 1'b0;
      svc_ready_s  = 1'b0;
      if (pause_s) begin
         src_s = SRC_IDLE;
      end else begin
         case (state_r)
            ST_INIT: begin
               src_s = SRC_IDLE;
               if (init_cnt_r == INIT_LAST) begin
                  state_s    = ST_RUN;
                  link_up_s  = 1'b1;
                  init_cnt_s = '0;
               end else begin
                  init_cnt_s = init_cnt_r + INIT_W'(1);
               end
            end
            ST_RUN: begin
               if (cc_due_s) begin
                  // The CC frame that opens a burst restarts the period count at zero
                  src_s       = SRC_CC;
                  cc_cnt_s    = '0;
                  burst_cnt_s = BURST_W'(1);
                  state_s     = (CC_COUNT > 1) ? ST_CC : ST_RUN;
               end else begin
                  cc_cnt_s = cc_cnt_r + CC_W'(1);
                  if (svc_valid_i && (!data_valid_i || !last_svc_r)) begin
                     src_s       = SRC_SVC;
                     svc_ready_s = 1'b1;
                     last_svc_s  = 1'b1;
                  end else if (data_valid_i) begin
                     src_s        = SRC_DATA;
                     data_ready_s = 1'b1;
                     last_svc_s   = 1'b0;
                  end else begin
                     src_s = SRC_IDLE;
                  end
               end
            end
            ST_CC: begin
               src_s    = SRC_CC;
               cc_cnt_s = cc_cnt_r + CC_W'(1);
               if (burst_cnt_r == BURST_LAST) begin
                  state_s     = ST_RUN;
                  burst_cnt_s = '0;
               end else begin
                  burst_cnt_s = burst_cnt_r + BURST_W'(1);
               end
            end
            default: begin
               state_s = ST_INIT;
               src_s   = SRC_IDLE;
            end
         endcase
      end
   end

   // Payload selection for the winning source
   always_comb begin
      frame_data_s = IDLE_WORD;
      case (src_s)
         SRC_DATA: frame_data_s = data_i;
         SRC_SVC:  frame_data_s = svc_i;
         SRC_CC:   frame_data_s = CC_WORD;
         SRC_IDLE: frame_data_s = IDLE_WORD;
         default:  frame_data_s = IDLE_WORD;
      endcase
   end

   // Scheduler state and scrambler-facing registers; payload holds across pause cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_INIT;
         init_cnt_r   <= '0;
         cc_cnt_r     <= '0;
         burst_cnt_r  <= '0;
         last_svc_r   <= 1'b0;
         link_up_r    <= 1'b0;
         scr_data_r   <= IDLE_WORD;
         scr_sync_r   <= SYNC_CTRL;
         scr_enable_r <= 1'b0;
      end else begin
         state_r      <= state_s;
         init_cnt_r   <= init_cnt_s;
         cc_cnt_r     <= cc_cnt_s;
         burst_cnt_r  <= burst_cnt_s;
         last_svc_r   <= last_svc_s;
         link_up_r    <= link_up_s;
         scr_enable_r <= ~pause_s;
         if (!pause_s) begin
            scr_data_r <= frame_data_s;
            scr_sync_r <= sync_of(src_s);
         end
      end
   end

   assign data_ready_o  = data_ready_s;
   assign svc_ready_o   = svc_ready_s;
   assign scr_data_o    = scr_data_r;
   assign scr_sync_o    = scr_sync_r;
   assign scr_enable_o  = scr_enable_r;
   assign tx_sequence_o = seq_s;
   assign link_up_o     = link_up_r;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler with INIT_IDLES=4, CC_PERIOD=10, CC_COUNT=3.
module tb_tx_frame_scheduler;
   import tx_frame_pkg::*;

   localparam logic [63:0] IDLE_W = 64'h7800_0000_0000_0000;
   localparam logic [63:0] CCW    = 64'h7880_0000_0000_0000;
   localparam logic [63:0] SVC0   = 64'h5000_0000_0000_0001;

   logic        clk, rst_n;
   logic [63:0] data_i, svc_i;
   logic        data_valid_i, svc_valid_i;
   logic        data_ready_o, svc_ready_o;
   logic [63:0] scr_data_o;
   logic [1:0]  scr_sync_o;
   logic        scr_enable_o;
   logic [5:0]  tx_sequence_o;
   logic        link_up_o;

   tx_frame_scheduler #(
      .INIT_IDLES (4),
      .CC_PERIOD  (10),
      .CC_COUNT   (3),
      .IDLE_WORD  (IDLE_W),
      .CC_WORD    (CCW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .data_i        (data_i),
      .data_valid_i  (data_valid_i),
      .data_ready_o  (data_ready_o),
      .svc_i         (svc_i),
      .svc_valid_i   (svc_valid_i),
      .svc_ready_o   (svc_ready_o),
      .scr_data_o    (scr_data_o),
      .scr_sync_o    (scr_sync_o),
      .scr_enable_o  (scr_enable_o),
      .tx_sequence_o (tx_sequence_o),
      .link_up_o     (link_up_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          k, slots, epoch;
   logic        last_svc, exp_en;
   logic [63:0] exp_data, exp_dval, exp_sval, src_dval, src_sval;
   logic [1:0]  exp_sync;
   logic [63:0] obs_data [0:199];
   logic [1:0]  obs_sync [0:199];
   logic        obs_en   [0:199];
   logic        obs_link [0:199];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s (k=%0d): got %h, expected %h", tag, k, got, want);
      end
   endtask

   task automatic model_reset();
      k        = 0;
      slots    = 0;
      last_svc = 1'b0;
      exp_en   = 1'b0;
      exp_data = IDLE_W;
      exp_sync = 2'b10;
   endtask

   // One cycle: drive, check outputs of the previous slot, check readies, predict next outputs.
   task automatic run_cycle(input logic dv, input logic sv);
      src_t t;
      int   f;
      logic pause;
      data_valid_i = dv;
      svc_valid_i  = sv;
      data_i       = src_dval;
      svc_i        = src_sval;
      @(negedge clk);
      check_val("tx_sequence", 64'(tx_sequence_o), 64'(k % 33));
      check_val("scr_enable", 64'(scr_enable_o), 64'(exp_en));
      check_val("scr_data", scr_data_o, exp_data);
      check_val("scr_sync", 64'(scr_sync_o), 64'(exp_sync));
      check_val("link_up", 64'(link_up_o), 64'(slots >= 4));
      if (epoch == 1 && k < 200) begin
         obs_data[k] = scr_data_o;
         obs_sync[k] = scr_sync_o;
         obs_en[k]   = scr_enable_o;
         obs_link[k] = link_up_o;
      end
      pause = ((k % 33) == 32);
      t     = SRC_IDLE;
      if (!pause && slots >= 4) begin
         f = slots - 3;
         if (f >= 10 && (f % 10) < 3) t = SRC_CC;
         else if (sv && (!dv || !last_svc)) t = SRC_SVC;
         else if (dv) t = SRC_DATA;
      end
      check_val("data_ready", 64'(data_ready_o), 64'(t == SRC_DATA));
      check_val("svc_ready", 64'(svc_ready_o), 64'(t == SRC_SVC));
      if (dv && data_ready_o) src_dval = src_dval + 64'd1;
      if (sv && svc_ready_o) src_sval = src_sval + 64'd1;
      exp_en = !pause;
      if (!pause) begin
         slots++;
         case (t)
            SRC_DATA: begin
               exp_data = exp_dval;
               exp_dval = exp_dval + 64'd1;
               exp_sync = 2'b01;
               last_svc = 1'b0;
            end
            SRC_SVC: begin
               exp_data = exp_sval;
               exp_sval = exp_sval + 64'd1;
               exp_sync = 2'b10;
               last_svc = 1'b1;
            end
            SRC_CC: begin
               exp_data = CCW;
               exp_sync = 2'b10;
            end
            default: begin
               exp_data = IDLE_W;
               exp_sync = 2'b10;
            end
         endcase
      end
      k++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n_cc;
      rst_n        = 1'b0;
      src_dval     = 64'd1;
      exp_dval     = 64'd1;
      src_sval     = SVC0;
      exp_sval     = SVC0;
      data_valid_i = 1'b1;
      svc_valid_i  = 1'b1;
      data_i       = src_dval;
      svc_i        = src_sval;
      epoch        = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_val("rst_scr_data", scr_data_o, IDLE_W);
      check_val("rst_scr_sync", 64'(scr_sync_o), 64'(2'b10));
      check_val("rst_scr_enable", 64'(scr_enable_o), 64'd0);
      check_val("rst_tx_sequence", 64'(tx_sequence_o), 64'd0);
      check_val("rst_link_up", 64'(link_up_o), 64'd0);
      check_val("rst_data_ready", 64'(data_ready_o), 64'd0);
      check_val("rst_svc_ready", 64'(svc_ready_o), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      epoch = 1;
      model_reset();

      for (int i = 0; i < 40; i++) run_cycle(1'b0, 1'b0);
      for (int i = 40; i < 110; i++) run_cycle(1'b1, 1'b0);
      for (int i = 110; i < 170; i++) run_cycle(1'b1, 1'b1);

      // Hand-derived spot checks on the first epoch.
      check_val("first_cycle_enable", 64'(obs_en[0]), 64'd0);
      check_val("first_idle_data", obs_data[1], IDLE_W);
      check_val("first_idle_enable", 64'(obs_en[1]), 64'd1);
      check_val("link_low_c3", 64'(obs_link[3]), 64'd0);
      check_val("link_high_c4", 64'(obs_link[4]), 64'd1);
      check_val("idle_cc_first", obs_data[14], CCW);
      check_val("idle_cc_last", obs_data[16], CCW);
      check_val("idle_after_cc", obs_data[17], IDLE_W);
      check_val("pause_enable_c32", 64'(obs_en[32]), 64'd1);
      check_val("pause_enable_c33", 64'(obs_en[33]), 64'd0);
      check_val("data_first", obs_data[41], 64'd1);
      check_val("data_first_sync", 64'(obs_sync[41]), 64'(2'b01));
      check_val("data_before_cc", obs_data[44], 64'd4);
      check_val("cc_after_9", obs_data[45], CCW);
      check_val("cc_third", obs_data[47], CCW);
      check_val("data_resume", obs_data[48], 64'd5);
      check_val("cc_pause_hold_data", obs_data[66], CCW);
      check_val("cc_pause_hold_en", 64'(obs_en[66]), 64'd0);
      n_cc = 0;
      for (int i = 60; i <= 70; i++) if (obs_en[i] && obs_data[i] == CCW) n_cc++;
      check_val("cc_span_count", 64'(n_cc), 64'd3);
      check_val("alt_svc_data", obs_data[111], SVC0);
      check_val("alt_svc_sync", 64'(obs_sync[111]), 64'(2'b10));
      check_val("alt_data_sync", 64'(obs_sync[112]), 64'(2'b01));
      check_val("alt_svc2_data", obs_data[113], SVC0 + 64'd1);

      // One-cycle reset pulse mid-stream, then INIT must run again.
      rst_n        = 1'b0;
      data_valid_i = 1'b0;
      svc_valid_i  = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      epoch = 2;
      model_reset();
      for (int i = 0; i < 30; i++) run_cycle(1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
